// File: rtl/ram_port_arb_pkg.sv
// Shared constants for the two-requester RAM port arbiter.
package ram_port_arb_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int OOB_BIT  = 15;
    localparam int STARVE_W = 4;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/ram_port_arb_starve_counter.sv
// Saturating starvation counter: counts denied cycles of the low-priority
// requester and flags when it has waited long enough to be promoted.
module starve_counter
    import ram_port_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/ram_port_arb.sv
// Arbiter for the single 32-bit RAM port shared by the CPU data path (m0)
// and the host loader/DMA engine (m1), with read return and range checking.
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_q
);

    // Handshake: a requester raises req with stable we/addr/wdata and holds them
    // until gnt is high in the same cycle; that cycle is the transfer. For a read,
    // rvalid qualifies rdata exactly one cycle later; writes have no response.

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    logic                m0_oob;
    logic                m1_oob;
    logic                rd_pend;
    logic                rd_who;
    logic                rd_oob;
    logic [DATA_W-1:0]   rd_data;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (m1_req && !m1_gnt),
        .clr      (m1_gnt || !m1_req),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    assign m0_oob = m0_addr[OOB_BIT];
    assign m1_oob = m1_addr[OOB_BIT];

    // m0 has priority unless m1 has waited MAX_WAIT cycles.
    assign m0_gnt = !reset && m0_req && (!m1_req || !starve_hit);
    assign m1_gnt = !reset && m1_req && (!m0_req || starve_hit);

    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_wr   = 1'b0;
        if (m1_gnt) begin
            ram_addr = m1_addr;
            ram_d    = m1_wdata;
            ram_wr   = m1_we && !m1_oob;
        end else if (m0_gnt) begin
            // m0 out-of-range reads alias onto the RAM; its writes are dropped.
            ram_addr = m0_addr;
            ram_d    = m0_wdata;
            ram_wr   = m0_we && !m0_oob;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_who  <= REQ_CPU;
            rd_oob  <= 1'b0;
            m1_err  <= 1'b0;
        end else begin
            rd_pend <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            rd_who  <= m1_gnt ? REQ_DMA : REQ_CPU;
            rd_oob  <= m1_gnt && m1_oob;
            m1_err  <= m1_gnt && m1_oob;
        end
    end

    // A read granted just before reset must not return while reset is held.
    assign m0_rvalid = rd_pend && !reset && (rd_who == REQ_CPU);
    assign m1_rvalid = rd_pend && !reset && (rd_who == REQ_DMA);

    assign rd_data  = rd_oob ? '0 : ram_q;
    assign m0_rdata = rd_data;
    assign m1_rdata = rd_data;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a registered-output RAM model on port A.
module tb_ram_port_arb;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_d, ram_q;
    logic        ram_wr;

    logic [31:0] mem [0:8191];
    int n_tests = 0;
    int n_fail  = 0;

    ram_port_arb #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .ram_addr  (ram_addr),
        .ram_d     (ram_d),
        .ram_wr    (ram_wr),
        .ram_q     (ram_q)
    );

    // Clock and RAM model (read-before-write, output registered).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr[14:2]] <= ram_d;
        ram_q <= mem[ram_addr[14:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle;
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0;
    endtask

    task automatic drive0(input logic we, input logic [15:0] a, input logic [31:0] d);
        m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic we, input logic [15:0] a, input logic [31:0] d);
        m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        ram_q = 32'h0;
        reset = 1'b1;
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
        drive0(1'b1, 16'h0000, 32'h0);
        drive1(1'b1, 16'h0004, 32'h0);
        #1;
        settle;
        check("rst_gnt0", m0_gnt, 1'b0);
        check("rst_gnt1", m1_gnt, 1'b0);
        check("rst_wr", ram_wr, 1'b0);
        tick;
        check("rst_rvalid0", m0_rvalid, 1'b0);
        check("rst_rvalid1", m1_rvalid, 1'b0);
        check("rst_err", m1_err, 1'b0);
        check("rst_starve", {28'h0, dut.starve_cnt}, 32'h0);
        reset = 1'b0;
        idle;

        // Preload through m0 writes.
        drive0(1'b1, 16'h0000, 32'h11110000);
        settle;
        check("pre_gnt0", m0_gnt, 1'b1);
        check("pre_wr", ram_wr, 1'b1);
        tick;
        drive0(1'b1, 16'h0004, 32'h22220004);
        settle;
        check("wr_no_rvalid", m0_rvalid, 1'b0);
        tick;
        drive0(1'b1, 16'h0010, 32'hDEADBEEF);
        tick;
        drive0(1'b1, 16'h0020, 32'hAAAA0020);
        tick;

        // Single m0 read.
        drive0(1'b0, 16'h0010, 32'h0);
        settle;
        check("rd_gnt0", m0_gnt, 1'b1);
        check("rd_gnt1", m1_gnt, 1'b0);
        check("rd_addr", ram_addr, 16'h0010);
        check("rd_wr", ram_wr, 1'b0);
        tick;
        idle;
        settle;
        check("rd_rvalid0", m0_rvalid, 1'b1);
        check("rd_rdata0", m0_rdata, 32'hDEADBEEF);
        check("rd_rvalid1", m1_rvalid, 1'b0);
        tick;

        // Starvation: both requesting, m1 wins every 5th cycle.
        drive0(1'b0, 16'h0000, 32'h0);
        drive1(1'b0, 16'h0004, 32'h0);
        for (int i = 0; i < 10; i++) begin
            settle;
            check("stv_gnt0", m0_gnt, (i == 4 || i == 9) ? 1'b0 : 1'b1);
            check("stv_gnt1", m1_gnt, (i == 4 || i == 9) ? 1'b1 : 1'b0);
            check("stv_cnt", {28'h0, dut.starve_cnt}, 32'(i % 5));
            if (i == 0) begin
                check("stv_rv0_first", m0_rvalid, 1'b0);
                check("stv_rv1_first", m1_rvalid, 1'b0);
            end else begin
                check("stv_rv0", m0_rvalid, (i == 5) ? 1'b0 : 1'b1);
                check("stv_rv1", m1_rvalid, (i == 5) ? 1'b1 : 1'b0);
                check("stv_rdata", m0_rdata, (i == 5) ? 32'h22220004 : 32'h11110000);
            end
            tick;
        end
        idle;
        settle;
        check("stv_tail_rv1", m1_rvalid, 1'b1);
        check("stv_tail_rv0", m0_rvalid, 1'b0);
        check("stv_tail_rdata", m1_rdata, 32'h22220004);
        tick;

        // m1 out-of-range write.
        drive1(1'b1, 16'h8004, 32'h12345678);
        settle;
        check("oob1_gnt", m1_gnt, 1'b1);
        check("oob1_wr", ram_wr, 1'b0);
        check("oob1_err_pre", m1_err, 1'b0);
        tick;
        idle;
        settle;
        check("oob1_err", m1_err, 1'b1);
        check("oob1_no_rvalid", m1_rvalid, 1'b0);
        tick;
        drive0(1'b0, 16'h0004, 32'h0);
        settle;
        check("oob1_err_once", m1_err, 1'b0);
        tick;
        idle;
        settle;
        check("oob1_prior_rv", m0_rvalid, 1'b1);
        check("oob1_prior_data", m0_rdata, 32'h22220004);
        tick;

        // m1 out-of-range read returns zero.
        drive1(1'b0, 16'h8010, 32'h0);
        settle;
        check("oob1r_gnt", m1_gnt, 1'b1);
        tick;
        idle;
        settle;
        check("oob1r_rvalid", m1_rvalid, 1'b1);
        check("oob1r_rdata", m1_rdata, 32'h0);
        check("oob1r_err", m1_err, 1'b1);
        tick;

        // m0 out-of-range: write dropped, read aliases, no error.
        drive0(1'b1, 16'h8000, 32'h55555555);
        settle;
        check("oob0_gnt", m0_gnt, 1'b1);
        check("oob0_wr", ram_wr, 1'b0);
        tick;
        drive0(1'b0, 16'h8010, 32'h0);
        settle;
        check("oob0_no_err", m1_err, 1'b0);
        tick;
        idle;
        settle;
        check("oob0_rvalid", m0_rvalid, 1'b1);
        check("oob0_alias", m0_rdata, 32'hDEADBEEF);
        tick;
        drive0(1'b0, 16'h0000, 32'h0);
        tick;
        idle;
        settle;
        check("oob0_dropped", m0_rdata, 32'h11110000);
        tick;

        // Alternating m0 / m1 reads.
        drive0(1'b0, 16'h0000, 32'h0);
        settle;
        check("alt_gnt0", m0_gnt, 1'b1);
        tick;
        m0_req = 1'b0;
        drive1(1'b0, 16'h0004, 32'h0);
        settle;
        check("alt_gnt1", m1_gnt, 1'b1);
        check("alt_rv0_a", m0_rvalid, 1'b1);
        check("alt_rv1_a", m1_rvalid, 1'b0);
        check("alt_data_a", m0_rdata, 32'h11110000);
        tick;
        m1_req = 1'b0;
        drive0(1'b0, 16'h0000, 32'h0);
        settle;
        check("alt_rv1_b", m1_rvalid, 1'b1);
        check("alt_rv0_b", m0_rvalid, 1'b0);
        check("alt_data_b", m1_rdata, 32'h22220004);
        tick;
        idle;
        settle;
        check("alt_rv0_c", m0_rvalid, 1'b1);
        check("alt_data_c", m0_rdata, 32'h11110000);
        tick;

        // Reset the cycle after an m0 read grant.
        drive0(1'b0, 16'h0010, 32'h0);
        drive1(1'b0, 16'h0000, 32'h0);
        settle;
        check("mr_gnt0", m0_gnt, 1'b1);
        tick;
        m0_req = 1'b0;
        reset = 1'b1;
        settle;
        check("mr_rv0_in_rst", m0_rvalid, 1'b0);
        check("mr_gnt1_in_rst", m1_gnt, 1'b0);
        tick;
        reset = 1'b0;
        settle;
        check("mr_rv0_after", m0_rvalid, 1'b0);
        check("mr_starve", {28'h0, dut.starve_cnt}, 32'h0);
        check("mr_gnt1", m1_gnt, 1'b1);
        tick;
        idle;
        settle;
        check("mr_rv1", m1_rvalid, 1'b1);
        check("mr_data1", m1_rdata, 32'h11110000);
        tick;

        // Read return overlapping a new write grant.
        drive0(1'b0, 16'h0020, 32'h0);
        settle;
        check("ov_gnt0", m0_gnt, 1'b1);
        tick;
        m0_req = 1'b0;
        drive1(1'b1, 16'h0020, 32'hBBBB0020);
        settle;
        check("ov_gnt1", m1_gnt, 1'b1);
        check("ov_wr", ram_wr, 1'b1);
        check("ov_rv0", m0_rvalid, 1'b1);
        check("ov_old", m0_rdata, 32'hAAAA0020);
        tick;
        m1_req = 1'b0;
        m1_we = 1'b0;
        drive0(1'b0, 16'h0020, 32'h0);
        settle;
        check("ov_gnt0_b", m0_gnt, 1'b1);
        tick;
        idle;
        settle;
        check("ov_rv0_b", m0_rvalid, 1'b1);
        check("ov_new", m0_rdata, 32'hBBBB0020);
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Two-requester arbiter for the 32-bit read/write port of the 32 KB data/instruction RAM. The CPU data path (requester 0) and the host loader/DMA engine (requester 1) share that single port. Requester 0 has fixed priority, bounded by a starvation counter that guarantees requester 1 service. The block also routes read data back to the winner, handles out-of-range addresses, and reports per-requester status.

## Interface

- `MAX_WAIT`, default 4: consecutive denied cycles of requester 1 after which it wins the next arbitration; range 1..15.
- `clk` in 1: single clock for the block and the RAM.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: access request; the requester holds it and its qualifiers stable until granted.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 16: byte address; bits [1:0] are ignored.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_gnt`, `m1_gnt` out 1: request accepted this cycle; combinational from current inputs and state.
- `m0_rvalid`, `m1_rvalid` out 1: read data valid, one cycle after the read grant.
- `m0_rdata`, `m1_rdata` out 32: read data, meaningful only while the matching rvalid is high.
- `m1_err` out 1: registered pulse; the previous granted m1 access had `addr[15]`=1.
- `ram_addr` out 16: to the RAM port A address.
- `ram_d` out 32: to the RAM port A write data.
- `ram_wr` out 1: to the RAM port A write enable.
- `ram_q` in 32: from RAM port A; registered in the RAM, valid the cycle after the address is presented.

## Operation

- Arbitration runs every cycle. At most one grant is issued per cycle.
  - If only one requester has `req` high, that requester wins.
  - If both are high, m0 wins, unless `starve_cnt == MAX_WAIT`; then m1 wins.
- `starve_cnt` is a 4-bit counter.
  - It increments when `m1_req`=1 and m1 is not granted, saturating at `MAX_WAIT`.
  - It clears when m1 is granted or `m1_req`=0.
- The winner's `addr`, `wdata` and `we` drive `ram_addr`, `ram_d` and `ram_wr` combinationally.
- With no grant: `ram_wr`=0 and `ram_addr`=0.
- Out-of-range access (`addr[15]`=1):
  - m1: the grant is still issued, `ram_wr` is forced 0, `m1_err` pulses the next cycle, and a read returns `rdata`=0 with `rvalid`=1.
  - m0: the grant is issued and writes are dropped silently. A read returns the RAM word at the aliased address (`addr[14:2]`). m0 gets no error.
- Read return pipeline. Registers `rd_pend` (1 bit), `rd_who` (1 bit) and `rd_oob` (1 bit) are loaded at the read grant.
  - The next cycle, `mX_rvalid`=1 for `rd_who`.
  - `rdata` = `rd_oob` ? 0 : `ram_q`.
  - Both `rdata` outputs carry the same value. Only the rvalid distinguishes the destination.
- A write grant produces no rvalid.
- Back-to-back grants are allowed every cycle, in any read/write mix and to either requester.
- A read return and a new grant can occur in the same cycle.

## Timing

- Grant latency is 0 cycles (same cycle as `req`) when the requester wins. Read data arrives exactly 1 cycle after the grant.
- Write commit: the RAM is updated at the clock edge that ends the grant cycle.
- Reset, at the first edge with `reset`=1:
  - `starve_cnt`=0, `rd_pend`=0, `m1_err`=0, so both rvalids are 0.
  - Grants are combinational but are forced 0 while `reset`=1, and `ram_wr`=0.
- Reset mid-read: a read granted in the cycle before reset is dropped and produces no rvalid.
- The worst-case wait for m1 under continuous m0 requests is `MAX_WAIT` cycles.
- The worst-case wait for m0 is 1 cycle, because m1 cannot win twice consecutively while `starve_cnt` is clear.

## Structure

- The shared package holds:
  - the requester index constants `REQ_CPU`=0 and `REQ_DMA`=1;
  - the RAM address width (16) and data width (32);
  - the out-of-range bit position (15).
- One sub-module is natural: `starve_counter`, a saturating up-counter with clear, compare-to-limit output and a `MAX_WAIT` parameter.
- All other logic is flat within `ram_port_arb`.

## Test plan

- Single m0 read of `0x0010` after m0 writes `0xDEADBEEF` to it → `m0_gnt` same cycle, `m0_rvalid`=1 next cycle with `m0_rdata`=`0xDEADBEEF`, and `m1_rvalid`=0.
- `m0_req` held high continuously with `m1_req` high, `MAX_WAIT`=4 → m1 is granted exactly on its 5th request cycle; m0 is granted on the next cycle, then the pattern repeats.
- m1 write `0x12345678` to `0x8004` → `m1_gnt`=1, `ram_wr`=0, `m1_err`=1 on the next cycle only. A read of `0x0004` returns the unchanged prior value.
- Alternating cycles: m0 read `0x0000`, m1 read `0x0004`, each with distinct preloaded data → rvalids alternate and each requester receives its own word, with no cross-delivery.
- `reset` asserted the cycle after an m0 read grant → no `m0_rvalid`; `starve_cnt` reads 0; the first post-reset m1 request alone is granted immediately.
- Same-cycle read return plus new write grant: m0 reads `0x0020`, then m1 writes `0x0020` → `m0_rdata` returns the old value, and the new value is visible to a subsequent read.
